// File: rtl/counter_sched.sv
// Shared down-counter time-shared among four requesters by round-robin arbitration.
// Each job runs from its loaded delay down to zero, then pulses done to its owner.
module counter_sched #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned NREQ  = 4
) (
    input  logic                  clk,
    input  logic                  counter_reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] delay_in,
    input  logic                  hold,
    output logic [NREQ-1:0]       grant,
    output logic [NREQ-1:0]       done,
    output logic [WIDTH-1:0]      count_out,
    output logic [1:0]            cur_id,
    output logic                  busy
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [1:0]       cur_id_q, cur_id_d;
    logic [NREQ-1:0]  grant_q, grant_d;
    logic [NREQ-1:0]  done_q, done_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [1:0]       winner;
    logic [1:0]       cand;

    // Scan offsets from farthest to nearest so the requester closest to ptr wins.
    always_comb begin
        winner = ptr_q;
        cand   = '0;
        for (int k = 3; k >= 0; k--) begin
            cand = ptr_q + 2'(k);
            if (req[cand]) begin
                winner = cand;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        cur_id_d = cur_id_q;
        grant_d  = grant_q;
        done_d   = done_q;
        count_d  = count_q;
        unique case (state_q)
            StIdle: begin
                grant_d = '0;
                done_d  = '0;
                if (|req) begin
                    state_d         = StRun;
                    cur_id_d        = winner;
                    grant_d[winner] = 1'b1;
                    count_d         = delay_in[32'(winner)*WIDTH +: WIDTH];
                end
            end
            StRun: begin
                if (!req[cur_id_q]) begin
                    state_d = StIdle;
                    grant_d = '0;
                    ptr_d   = cur_id_q + 2'd1;
                end else if (count_q == '0) begin
                    state_d          = StDone;
                    done_d[cur_id_q] = 1'b1;
                end else if (!hold) begin
                    count_d = count_q - WIDTH'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
                done_d  = '0;
                grant_d = '0;
                ptr_d   = cur_id_q + 2'd1;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge counter_reset) begin
        if (counter_reset) begin
            state_q  <= StIdle;
            ptr_q    <= '0;
            cur_id_q <= '0;
            grant_q  <= '0;
            done_q   <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            cur_id_q <= cur_id_d;
            grant_q  <= grant_d;
            done_q   <= done_d;
            count_q  <= count_d;
        end
    end

    assign grant     = grant_q;
    assign done      = done_q;
    assign count_out = count_q;
    assign cur_id    = cur_id_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_counter_sched.sv
// Randomized and directed bench for counter_sched against a job-level reference model.
module tb_counter_sched;

    localparam int W = 16;
    localparam int N = 4;

    localparam int PIdle = 0;
    localparam int PRun  = 1;
    localparam int PFin  = 2;

    logic           clk;
    logic           counter_reset;
    logic [N-1:0]   req;
    logic [N*W-1:0] delay_in;
    logic           hold;
    logic [N-1:0]   grant;
    logic [N-1:0]   done;
    logic [W-1:0]   count_out;
    logic [1:0]     cur_id;
    logic           busy;

    int n_total;
    int n_bad;

    // Reference model: which job phase we are in, who owns it, how much is left.
    int m_phase;
    int m_ptr;
    int m_owner;
    int m_cnt;

    counter_sched #(
        .WIDTH(W),
        .NREQ (N)
    ) dut (
        .clk          (clk),
        .counter_reset(counter_reset),
        .req          (req),
        .delay_in     (delay_in),
        .hold         (hold),
        .grant        (grant),
        .done         (done),
        .count_out    (count_out),
        .cur_id       (cur_id),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return p;
    endfunction

    task automatic model_reset();
        m_phase = PIdle;
        m_ptr   = 0;
        m_owner = 0;
        m_cnt   = 0;
    endtask

    task automatic model_edge();
        case (m_phase)
            PIdle: begin
                if (req != 0) begin
                    m_owner = rr_pick(req, m_ptr);
                    m_cnt   = int'(delay_in[m_owner*W +: W]);
                    m_phase = PRun;
                end
            end
            PRun: begin
                if (!req[m_owner]) begin
                    m_phase = PIdle;
                    m_ptr   = (m_owner + 1) % N;
                end else if (m_cnt == 0) begin
                    m_phase = PFin;
                end else if (!hold) begin
                    m_cnt = m_cnt - 1;
                end
            end
            default: begin
                m_phase = PIdle;
                m_ptr   = (m_owner + 1) % N;
            end
        endcase
    endtask

    task automatic compare_all();
        logic [N-1:0] eg;
        logic [N-1:0] ed;
        eg = (m_phase != PIdle) ? (4'b0001 << m_owner) : 4'b0000;
        ed = (m_phase == PFin) ? (4'b0001 << m_owner) : 4'b0000;
        check_eq("grant", 32'(grant), 32'(eg));
        check_eq("done", 32'(done), 32'(ed));
        check_eq("count_out", 32'(count_out), 32'(m_cnt));
        check_eq("cur_id", 32'(cur_id), 32'(m_owner));
        check_eq("busy", 32'(busy), 32'(m_phase != PIdle));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic apply_reset();
        req           = '0;
        hold          = 1'b0;
        delay_in      = '0;
        counter_reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        @(negedge clk);
        counter_reset = 1'b0;
    endtask

    int n_edges;

    initial begin
        n_total = 0;
        n_bad   = 0;
        model_reset();
        counter_reset = 1'b1;
        req           = '0;
        hold          = 1'b0;
        delay_in      = '0;
        #2;
        check_eq("rst_async_grant", 32'(grant), 32'd0);
        check_eq("rst_async_count", 32'(count_out), 32'd0);
        apply_reset();

        // Single job, D=3.
        req             = 4'b0001;
        delay_in[0+:W]  = 16'd3;
        step();
        check_eq("j1_grant_e1", 32'(grant), 32'h1);
        check_eq("j1_cnt_e1", 32'(count_out), 32'd3);
        for (int i = 2; i >= 0; i--) begin
            step();
            check_eq("j1_cnt_dec", 32'(count_out), 32'(i));
        end
        step();
        check_eq("j1_done_e5", 32'(done), 32'h1);
        req = 4'b0000;
        step();
        check_eq("j1_grant_e6", 32'(grant), 32'h0);
        check_eq("j1_done_e6", 32'(done), 32'h0);

        // All requesting, all D=0: rotation every 3 edges.
        apply_reset();
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            step();
            check_eq("rr_grant", 32'(grant), 32'(4'b0001 << (k % 4)));
            check_eq("rr_cnt_zero", 32'(count_out), 32'd0);
            step();
            check_eq("rr_done", 32'(done), 32'(4'b0001 << (k % 4)));
            step();
            check_eq("rr_gap", 32'(grant), 32'h0);
        end
        req = 4'b0000;

        // Abort mid-job advances the pointer past the aborted owner.
        apply_reset();
        req            = 4'b0001;
        delay_in[0+:W] = 16'd5;
        step();
        for (int i = 0; i < 10 && count_out != 16'd2; i++) step();
        check_eq("ab_reach_cnt2", 32'(count_out), 32'd2);
        req = 4'b0000;
        step();
        check_eq("ab_grant", 32'(grant), 32'h0);
        check_eq("ab_busy", 32'(busy), 32'd0);
        check_eq("ab_nodone", 32'(done), 32'h0);
        req            = 4'b0011;
        delay_in[W+:W] = 16'd1;
        step();
        check_eq("ab_next_grant", 32'(grant), 32'h2);

        // Hold freezes the count for exactly its duration.
        apply_reset();
        req            = 4'b0001;
        delay_in[0+:W] = 16'd4;
        step();
        n_edges = 0;
        for (int i = 0; i < 10 && count_out != 16'd2; i++) begin
            step();
            n_edges++;
        end
        check_eq("hd_reach_cnt2", 32'(count_out), 32'd2);
        hold = 1'b1;
        repeat (3) begin
            step();
            n_edges++;
            check_eq("hd_frozen", 32'(count_out), 32'd2);
        end
        hold = 1'b0;
        for (int i = 0; i < 20 && done == 4'b0000; i++) begin
            step();
            n_edges++;
        end
        check_eq("hd_done", 32'(done), 32'h1);
        check_eq("hd_done_edges", 32'(n_edges), 32'd8);

        // Asynchronous reset between edges drops the job.
        apply_reset();
        req            = 4'b0001;
        delay_in[0+:W] = 16'd9;
        repeat (3) step();
        check_eq("ar_cnt7", 32'(count_out), 32'd7);
        #2;
        counter_reset = 1'b1;
        model_reset();
        #1;
        check_eq("ar_grant", 32'(grant), 32'h0);
        check_eq("ar_done", 32'(done), 32'h0);
        check_eq("ar_cnt", 32'(count_out), 32'd0);
        check_eq("ar_busy", 32'(busy), 32'd0);
        req = 4'b0000;
        @(negedge clk);
        counter_reset = 1'b0;
        repeat (12) begin
            step();
            check_eq("ar_no_done", 32'(done), 32'h0);
        end

        // Maximum delay loads intact and decrements once.
        apply_reset();
        req            = 4'b0001;
        delay_in[0+:W] = 16'hFFFF;
        step();
        check_eq("max_load", 32'(count_out), 32'hFFFF);
        step();
        check_eq("max_dec", 32'(count_out), 32'hFFFE);

        // Randomized traffic: requesters hold until done, occasionally abort.
        apply_reset();
        for (int c = 0; c < 3000; c++) begin
            step();
            for (int i = 0; i < N; i++) begin
                if (req[i] && m_phase == PFin && m_owner == i) req[i] = 1'b0;
                else if (!req[i]) req[i] = ($urandom_range(0, 3) == 0);
                else if ($urandom_range(0, 59) == 0) req[i] = 1'b0;
                delay_in[i*W +: W] = 16'($urandom_range(0, 6));
            end
            hold = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 399) == 0) begin
                #2;
                counter_reset = 1'b1;
                model_reset();
                #1;
                compare_all();
                @(negedge clk);
                counter_reset = 1'b0;
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
